// File: rtl/dlsc_demosaic_pkg.sv
// Shared definitions for the VNG demosaic sequencer and output stages:
// FSM encoding, phase-counter width helper and the border-mask compare.
package dlsc_demosaic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } seq_state_e;

    // Width of a counter that spans 0..n-1; never narrower than one bit.
    function automatic int calc_sb(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Signed compare: with lim < 2*margin the window is empty instead of wrapping.
    function automatic logic in_border(input int pos, input int lim, input int margin);
        return (pos < margin) || (pos > (lim - margin));
    endfunction

endpackage

// File: rtl/dlsc_demosaic_seq_pos.sv
// Raster position tracker: x/y counters plus the per-pixel last-column,
// end-of-frame, row parity and border-mask flags for the current position.
module dlsc_demosaic_seq_pos
    import dlsc_demosaic_pkg::*;
#(
    parameter int XB     = 12,
    parameter int YB     = 12,
    parameter int MARGIN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic [XB-1:0] cfg_width,
    input  logic [YB-1:0] cfg_height,
    output logic          at_last,
    output logic          at_end,
    output logic          row_odd,
    output logic          masked
);

    logic [XB-1:0] x_q, x_d;
    logic [YB-1:0] y_q, y_d;

    // NOTE: every always_comb output gets its hold value first, so no path infers a latch.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (at_last) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign at_last = (x_q == cfg_width);
    assign at_end  = at_last && (y_q == cfg_height);
    assign row_odd = y_q[0];
    assign masked  = in_border(int'(x_q), int'(cfg_width), MARGIN) ||
                     in_border(int'(y_q), int'(cfg_height), MARGIN);

endmodule

// File: rtl/dlsc_demosaic_seq.sv
// Bayer pixel sequencer: accepts one raw pixel per phase period and presents it
// on the px_* bus at phase 0, followed by masked zero pixels to flush the pipe.
module dlsc_demosaic_seq
    import dlsc_demosaic_pkg::*;
#(
    parameter  int DATA     = 8,
    parameter  int XB       = 12,
    parameter  int YB       = 12,
    parameter  int STATES   = 12,
    parameter  int MARGIN   = 2,
    parameter  int FLUSH_PX = 4,
    localparam int SB       = calc_sb(STATES)
) (
    input  logic            clk,
    input  logic            clk_en,
    input  logic            rst,
    input  logic            start,
    input  logic [XB-1:0]   cfg_width,
    input  logic [YB-1:0]   cfg_height,
    input  logic            cfg_first_red,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DATA-1:0] in_data,
    output logic [SB-1:0]   st,
    output logic            px_push,
    output logic            px_masked,
    output logic            px_last,
    output logic            px_row_red,
    output logic [DATA-1:0] px_in,
    output logic            frame_done
);

    localparam int FB = calc_sb(FLUSH_PX);

    seq_state_e      state_q, state_d;
    logic [SB-1:0]   st_q, st_d;
    logic [XB-1:0]   cfg_width_q, cfg_width_d;
    logic [YB-1:0]   cfg_height_q, cfg_height_d;
    logic            cfg_red_q, cfg_red_d;
    logic [FB-1:0]   flush_cnt_q, flush_cnt_d;
    logic            px_push_q, px_push_d;
    logic            px_masked_q, px_masked_d;
    logic            px_last_q, px_last_d;
    logic            px_row_red_q, px_row_red_d;
    logic [DATA-1:0] px_in_q, px_in_d;
    logic            frame_done_q, frame_done_d;

    logic slot;
    logic pos_clear, pos_advance;
    logic pos_last, pos_end, pos_row_odd, pos_masked;

    dlsc_demosaic_seq_pos #(
        .XB     (XB),
        .YB     (YB),
        .MARGIN (MARGIN)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .clear      (pos_clear),
        .advance    (pos_advance),
        .cfg_width  (cfg_width_q),
        .cfg_height (cfg_height_q),
        .at_last    (pos_last),
        .at_end     (pos_end),
        .row_odd    (pos_row_odd),
        .masked     (pos_masked)
    );

    assign slot     = (st_q == SB'(STATES - 1));
    assign in_ready = clk_en && (state_q == RUN) && slot;

    always_comb begin
        state_d      = state_q;
        st_d         = st_q;
        cfg_width_d  = cfg_width_q;
        cfg_height_d = cfg_height_q;
        cfg_red_d    = cfg_red_q;
        flush_cnt_d  = flush_cnt_q;
        px_push_d    = px_push_q;
        px_masked_d  = px_masked_q;
        px_last_d    = px_last_q;
        px_row_red_d = px_row_red_q;
        px_in_d      = px_in_q;
        frame_done_d = frame_done_q;
        pos_clear    = 1'b0;
        pos_advance  = 1'b0;

        // With clk_en low every register keeps its value, including the pulses.
        if (clk_en) begin
            st_d         = slot ? '0 : st_q + 1'b1;
            px_push_d    = 1'b0;
            frame_done_d = 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d      = RUN;
                        cfg_width_d  = cfg_width;
                        cfg_height_d = cfg_height;
                        cfg_red_d    = cfg_first_red;
                        pos_clear    = 1'b1;
                    end
                end
                RUN: begin
                    if (slot && in_valid) begin
                        px_push_d    = 1'b1;
                        px_in_d      = in_data;
                        px_last_d    = pos_last;
                        px_row_red_d = cfg_red_q ^ pos_row_odd;
                        px_masked_d  = pos_masked;
                        pos_advance  = 1'b1;
                        if (pos_end) begin
                            state_d     = FLUSH;
                            flush_cnt_d = '0;
                        end
                    end
                end
                FLUSH: begin
                    if (slot) begin
                        px_push_d   = 1'b1;
                        px_in_d     = '0;
                        px_masked_d = 1'b1;
                        px_last_d   = 1'b0;
                        if (flush_cnt_q == FB'(FLUSH_PX - 1)) begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            flush_cnt_d = flush_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            st_q         <= '0;
            cfg_width_q  <= '0;
            cfg_height_q <= '0;
            cfg_red_q    <= 1'b0;
            flush_cnt_q  <= '0;
            px_push_q    <= 1'b0;
            px_masked_q  <= 1'b0;
            px_last_q    <= 1'b0;
            px_row_red_q <= 1'b0;
            px_in_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            st_q         <= st_d;
            cfg_width_q  <= cfg_width_d;
            cfg_height_q <= cfg_height_d;
            cfg_red_q    <= cfg_red_d;
            flush_cnt_q  <= flush_cnt_d;
            px_push_q    <= px_push_d;
            px_masked_q  <= px_masked_d;
            px_last_q    <= px_last_d;
            px_row_red_q <= px_row_red_d;
            px_in_q      <= px_in_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign st         = st_q;
    assign px_push    = px_push_q;
    assign px_masked  = px_masked_q;
    assign px_last    = px_last_q;
    assign px_row_red = px_row_red_q;
    assign px_in      = px_in_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dlsc_demosaic_seq.sv
// Scoreboard bench for dlsc_demosaic_seq: a raster model queues the expected
// pixel/flush sequence per frame and a monitor checks every px_push against it.
module tb_dlsc_demosaic_seq;

    localparam int DATA     = 8;
    localparam int XB       = 12;
    localparam int YB       = 12;
    localparam int STATES   = 4;
    localparam int MG       = 2;
    localparam int FLUSH_PX = 4;
    localparam int SB       = 2;
    localparam int BUDGET   = 3000;

    typedef struct {
        logic [DATA-1:0] data;
        bit              masked;
        bit              last;
        bit              row_red;
        bit              done;
    } exp_t;

    logic            clk = 1'b0;
    logic            clk_en, rst, start, cfg_first_red, in_valid, in_ready;
    logic [XB-1:0]   cfg_width;
    logic [YB-1:0]   cfg_height;
    logic [DATA-1:0] in_data;
    logic [SB-1:0]   st;
    logic            px_push, px_masked, px_last, px_row_red, frame_done;
    logic [DATA-1:0] px_in;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_cnt   = 0;
    int   prev_cnt = 0;
    int   done_cnt = 0;
    bit   en_edge  = 0;
    bit   have_prev = 0;
    bit   tight    = 0;

    dlsc_demosaic_seq #(
        .DATA(DATA), .XB(XB), .YB(YB), .STATES(STATES), .MARGIN(MG), .FLUSH_PX(FLUSH_PX)
    ) dut (
        .clk(clk), .clk_en(clk_en), .rst(rst), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_first_red(cfg_first_red),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .st(st), .px_push(px_push), .px_masked(px_masked), .px_last(px_last),
        .px_row_red(px_row_red), .px_in(px_in), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Registers only move on enabled edges, so that is when a push is new.
    initial forever begin
        @(posedge clk);
        en_edge = clk_en && !rst;
        if (en_edge) en_cnt++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (en_edge) begin
            if (frame_done) done_cnt++;
            if (px_push) begin
                check("push_phase", 32'(st), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_push", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("px_in", 32'(px_in), 32'(e.data));
                    check("px_masked", 32'(px_masked), 32'(e.masked));
                    check("px_last", 32'(px_last), 32'(e.last));
                    check("px_row_red", 32'(px_row_red), 32'(e.row_red));
                    check("frame_done", 32'(frame_done), 32'(e.done));
                    if (tight && have_prev) check("push_spacing", 32'(en_cnt - prev_cnt), 32'(STATES));
                    have_prev = 1;
                    prev_cnt  = en_cnt;
                end
            end else if (frame_done) begin
                check("done_without_push", 32'd1, 32'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_st"}, 32'(st), 32'd0);
        check({tag, "_px_push"}, 32'(px_push), 32'd0);
        check({tag, "_px_masked"}, 32'(px_masked), 32'd0);
        check({tag, "_px_last"}, 32'(px_last), 32'd0);
        check({tag, "_px_row_red"}, 32'(px_row_red), 32'd0);
        check({tag, "_px_in"}, 32'(px_in), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic run_frame(input int w, input int h, input bit red, input bit idx_data,
                             input bit en_rand, input int drop_at, input int abort_at,
                             input int restart_at);
        logic [DATA-1:0] pix[$];
        exp_t e;
        int   n, idx, cyc, drop, done_before;
        bit   dropped;
        n = (w + 1) * (h + 1);
        for (int y = 0; y <= h; y++) begin
            for (int x = 0; x <= w; x++) begin
                e.data    = idx_data ? DATA'(y * (w + 1) + x) : DATA'($urandom);
                e.masked  = (x < MG) || (x > w - MG) || (y < MG) || (y > h - MG);
                e.last    = (x == w);
                e.row_red = red ^ y[0];
                e.done    = 0;
                pix.push_back(e.data);
                exp_q.push_back(e);
            end
        end
        for (int f = 0; f < FLUSH_PX; f++) begin
            e.data    = '0;
            e.masked  = 1;
            e.last    = 0;
            e.row_red = red ^ h[0];
            e.done    = (f == FLUSH_PX - 1);
            exp_q.push_back(e);
        end
        done_before = done_cnt;
        have_prev   = 0;
        tight       = (drop_at < 0);

        @(negedge clk);
        clk_en = 1; start = 1; in_valid = 0;
        cfg_width = XB'(w); cfg_height = YB'(h); cfg_first_red = red;
        @(negedge clk);
        start = 0;

        idx = 0; cyc = 0; drop = 0; dropped = 0;
        while (idx < n && cyc < BUDGET) begin
            if (idx == abort_at) begin
                in_valid = 0; start = 0; clk_en = 1; rst = 1;
                @(negedge clk);
                rst = 0;
                check_reset_outputs("abort");
                exp_q.delete();
                repeat (40) @(negedge clk);
                check("no_done_after_abort", 32'(done_cnt), 32'(done_before));
                return;
            end
            clk_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == drop_at && !dropped) begin
                drop    = 3 * STATES;
                dropped = 1;
            end
            in_valid = (drop == 0);
            if (drop > 0) drop--;
            in_data = pix[idx];
            if (idx == restart_at) begin
                start = 1; cfg_width = XB'(w + 3); cfg_height = YB'(h + 2); cfg_first_red = ~red;
            end else begin
                start = 0; cfg_width = XB'(w); cfg_height = YB'(h); cfg_first_red = red;
            end
            #1;
            if (!clk_en) check("ready_while_disabled", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 0; start = 0;
        while (exp_q.size() > 0 && cyc < BUDGET) begin
            clk_en = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("frame_drained", 32'(exp_q.size()), 32'd0);
        check("frame_done_count", 32'(done_cnt), 32'(done_before + 1));
        exp_q.delete();
        clk_en = 1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1; clk_en = 1; start = 0; in_valid = 0; in_data = '0;
        cfg_width = '0; cfg_height = '0; cfg_first_red = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;
        @(negedge clk);

        run_frame(5, 3, 1, 1, 0, -1, -1, -1);   // 6x4, all masked, index data
        run_frame(7, 7, 0, 0, 0, -1, -1, -1);   // 8x8, 4x4 unmasked window
        run_frame(7, 7, 0, 0, 0, 12, -1, -1);   // valid dropped 3 periods mid-row
        run_frame(5, 4, 1, 0, 1, -1, -1, -1);   // random clock enable
        run_frame(7, 7, 1, 0, 0, -1, 10, -1);   // reset at pixel 10
        run_frame(7, 7, 1, 0, 0, -1, -1, -1);   // clean frame after abort
        run_frame(7, 5, 0, 0, 0, -1, -1, 5);    // start during RUN ignored
        run_frame(0, 0, 0, 0, 0, -1, -1, -1);   // 1x1 frame, fully masked

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dlsc_demosaic_seq.md
# dlsc_demosaic_seq

Parametrised pixel sequencer for the VNG demosaic pipeline. It accepts a raw Bayer stream over a valid/ready handshake and emits one pixel per phase period on the shared `st` phase bus together with `px_push`, `px_masked`, `px_last`, `px_row_red` and `px_in`. It generalises the fixed-period, fixed-pattern sequencing the VNG6 stages consume: phase count, frame geometry, border margin, Bayer phase and end-of-frame flush are all configurable. It sits between the frame source and the VNG stage chain.

## Interface
- `DATA`, 8, pixel width
- `XB`, 12, column counter width
- `YB`, 12, row counter width
- `STATES`, 12, phase period in cycles (≥2); `SB = $clog2(STATES)`
- `MARGIN`, 2, border pixels masked on every edge
- `FLUSH_PX`, 4, masked zero pixels emitted after the last frame pixel

Ports:
- `clk`  in  1  clock
- `clk_en`  in  1  global clock enable
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin frame; latches cfg_*
- `cfg_width`  in  XB  columns−1
- `cfg_height`  in  YB  rows−1
- `cfg_first_red`  in  1  row 0 contains red
- `in_valid`  in  1  input pixel valid
- `in_ready`  out  1  input pixel accepted this cycle when valid
- `in_data`  in  DATA  raw Bayer pixel
- `st`  out  SB  phase, 0..STATES−1
- `px_push`  out  1  new pixel this period
- `px_masked`  out  1  pixel in border or flush
- `px_last`  out  1  last column of row
- `px_row_red`  out  1  current row contains red
- `px_in`  out  DATA  pixel data
- `frame_done`  out  1  one-cycle pulse at end of flush

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE → RUN on `start`; cfg latched; x=y=0.
  - RUN → FLUSH after accepting pixel (x=cfg_width, y=cfg_height).
  - FLUSH → IDLE after FLUSH_PX pushes, with `frame_done` asserted for 1 cycle at that transition.
- `start` outside IDLE is ignored.
- `st` free-runs modulo STATES whenever `clk_en`=1, in every state.
- Accept slot is `st==STATES−1`.
- `in_ready = clk_en & RUN & st==STATES−1`.
- On accept:
  - register `px_in=in_data`, `px_push=1` for the next cycle (st==0).
  - `px_last = (x==cfg_width)`.
  - `px_row_red = cfg_first_red ^ y[0]`.
  - `px_masked = x<MARGIN | x>cfg_width−MARGIN | y<MARGIN | y>cfg_height−MARGIN`.
  - Then advance x; on wrap, x→0 and y+1.
- Slot with no accept (bubble): `px_push=0`; other px_* hold.
- FLUSH: each accept slot pushes `px_in=0`, `px_masked=1`, `px_last=0`, `px_row_red` unchanged; the input is not consumed.
- Comparisons use XB+1/YB+1 bit signed arithmetic, so frames smaller than 2·MARGIN mask every pixel with no wrap error.
- `clk_en`=0: all registers hold; `in_ready`=0.

## Timing
- Reset values: st=0, px_push=0, px_masked=0, px_last=0, px_row_red=0, px_in=0, in_ready=0, frame_done=0, FSM=IDLE, x=y=0.
- Latency: accept at cycle with st=STATES−1 → `px_push` high on the following enabled cycle (st=0), low otherwise. `px_push` is high only at st=0.
- Maximum throughput: 1 pixel / STATES enabled cycles.
- `rst` mid-frame: the partial frame is discarded with no `frame_done`; RUN/FLUSH → IDLE. Reset overrides `start` in the same cycle.
- `frame_done` and the last flush `px_push` occur in the same cycle.

## Structure
- Shared package `dlsc_demosaic_pkg`: FSM state enum, `SB` calc function, margin/border compare function shared with the out stage.
- Single flat module. An optional sub-module `dlsc_demosaic_seq_pos` (x/y counters + mask/last/row_red) is natural and reusable by the out stage.

## Test plan
- STATES=4, cfg 5×3 (6×4 frame), continuous valid, data=index → 24 pushes at st=0, each 4 cycles apart. px_last on x=5. Unmasked only at (2..3, 2..1 → none): every pixel masked since height 4 < 2·MARGIN+1. Then 4 flush pushes and frame_done.
- 8×8 frame, cfg_first_red=0 → px_row_red=1 on odd rows. Unmasked exactly x,y ∈ [2,5] (16 pixels).
- in_valid dropped for 3 periods mid-row → 3 bubbles with px_push=0, x unchanged, no data lost or duplicated.
- clk_en toggled 50% random → identical px_* sequence as with clk_en=1, stretched; in_ready never high while clk_en=0.
- rst asserted at pixel 10 of a frame → all outputs reset next cycle, no frame_done. A new start then gives a correct full frame.
- start pulsed during RUN with different cfg → ignored; the current frame completes with the original geometry.
